// File: rtl/alu_seq_pkg.sv
// Shared constants for the 8051 ALU issue/writeback sequencer.
// Holds the ALU opcode encoding (shared with the ALU core), the sequencer FSM
// state encoding, PSW bit positions and operand-2 source select codes.
package alu_seq_pkg;

  // ALU opcodes, identical to the encoding decoded by the ALU core.
  localparam logic [2:0] OpInc  = 3'b000;
  localparam logic [2:0] OpDec  = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpAddc = 3'b011;
  localparam logic [2:0] OpSubb = 3'b100;
  localparam logic [2:0] OpOrl  = 3'b101;
  localparam logic [2:0] OpXrl  = 3'b110;
  localparam logic [2:0] OpAnl  = 3'b111;

  // Sequencer FSM states.
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRd1  = 3'd1;
  localparam logic [2:0] StRd2  = 3'd2;
  localparam logic [2:0] StExec = 3'd3;
  localparam logic [2:0] StWb   = 3'd4;

  // PSW bit positions.
  localparam int unsigned PswCyBit = 7;
  localparam int unsigned PswAcBit = 6;
  localparam int unsigned PswOvBit = 2;
  localparam int unsigned PswPBit  = 0;

  // Operand-2 source select; the reserved code 2'b11 behaves as SrcImm.
  localparam logic [1:0] SrcRam = 2'b00;
  localparam logic [1:0] SrcImm = 2'b01;
  localparam logic [1:0] SrcAcc = 2'b10;

  // Only the arithmetic ops update CY/AC/OV.
  function automatic logic op_writes_flags(input logic [2:0] op);
    return (op == OpAdd) || (op == OpAddc) || (op == OpSubb);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle issue/writeback controller for the 8051 ALU core.
// Accepts one decoded request, fetches operands (ACC, internal RAM or
// immediate), drives the external combinational ALU and writes the result back
// to ACC or RAM together with PSW. Fixed 5-cycle occupancy: IDLE (accept),
// RD1, RD2, EXEC, WB.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   req_*                        decoder request (valid/ready handshake)
//   acc_in, psw_in               current ACC / PSW, sampled on accept
//   ram_rd_*                     RAM read port, data returns one cycle later
//   ram_wr_*, acc_wr_*, psw_wr_* single-cycle writeback strobes
//   alu_opcode/op1/op2/carry_in  ALU drive, valid in EXEC and WB
//   alu_result/cy/ac/ov          ALU outputs, only used in WB
//   done                         one-cycle completion pulse in WB
//
// Build option: ALU_SEQ_PARITY_EN -- recompute PSW.P from the result whenever
// ACC is written (and write PSW for every ACC-destination op).
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic       req_dst_acc,
  input  logic [7:0] req_dst_addr,
  input  logic [1:0] req_src_sel,
  input  logic [7:0] req_src_addr,
  input  logic [7:0] req_imm,
  input  logic [7:0] acc_in,
  input  logic [7:0] psw_in,
  output logic       ram_rd_en,
  output logic [7:0] ram_rd_addr,
  input  logic [7:0] ram_rd_data,
  output logic       ram_wr_en,
  output logic [7:0] ram_wr_addr,
  output logic [7:0] ram_wr_data,
  output logic       acc_wr_en,
  output logic [7:0] acc_wr_data,
  output logic       psw_wr_en,
  output logic [7:0] psw_wr_data,
  output logic [2:0] alu_opcode,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  output logic       alu_carry_in,
  input  logic [7:0] alu_result,
  input  logic       alu_cy,
  input  logic       alu_ac,
  input  logic       alu_ov,
  output logic       done
);

  logic [2:0] state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       dst_acc_q, dst_acc_d;
  logic [7:0] dst_addr_q, dst_addr_d;
  logic [1:0] src_sel_q, src_sel_d;
  logic [7:0] src_addr_q, src_addr_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] psw_q, psw_d;
  logic [7:0] op1_q, op1_d;
  logic [7:0] op2_q, op2_d;

  logic [7:0] op2_sel;
  logic [7:0] psw_new;

  // Operand 2 as seen during EXEC; the RAM read issued in RD2 lands here.
  always_comb begin
    op2_sel = imm_q;
    if (src_sel_q == SrcRam) begin
      op2_sel = ram_rd_data;
    end else if (src_sel_q == SrcAcc) begin
      op2_sel = acc_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dst_acc_d  = dst_acc_q;
    dst_addr_d = dst_addr_q;
    src_sel_d  = src_sel_q;
    src_addr_d = src_addr_q;
    imm_d      = imm_q;
    acc_d      = acc_q;
    psw_d      = psw_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d       = req_op;
          dst_acc_d  = req_dst_acc;
          dst_addr_d = req_dst_addr;
          src_sel_d  = req_src_sel;
          src_addr_d = req_src_addr;
          imm_d      = req_imm;
          acc_d      = acc_in;
          psw_d      = psw_in;
          state_d    = StRd1;
        end
      end
      StRd1: state_d = StRd2;
      StRd2: begin
        op1_d   = dst_acc_q ? acc_q : ram_rd_data;
        state_d = StExec;
      end
      StExec: begin
        // Latch op2 so the ALU inputs stay stable through WB.
        op2_d   = op2_sel;
        state_d = StWb;
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    ram_rd_en    = 1'b0;
    ram_rd_addr  = '0;
    ram_wr_en    = 1'b0;
    ram_wr_addr  = '0;
    ram_wr_data  = '0;
    acc_wr_en    = 1'b0;
    acc_wr_data  = '0;
    psw_wr_en    = 1'b0;
    psw_wr_data  = '0;
    alu_opcode   = '0;
    alu_op1      = '0;
    alu_op2      = '0;
    alu_carry_in = 1'b0;
    done         = 1'b0;
    psw_new      = psw_q;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StRd1: begin
        if (!dst_acc_q) begin
          ram_rd_en   = 1'b1;
          ram_rd_addr = dst_addr_q;
        end
      end
      StRd2: begin
        if (src_sel_q == SrcRam) begin
          ram_rd_en   = 1'b1;
          ram_rd_addr = src_addr_q;
        end
      end
      StExec: begin
        alu_opcode   = op_q;
        alu_op1      = op1_q;
        alu_op2      = op2_sel;
        alu_carry_in = psw_q[PswCyBit];
      end
      StWb: begin
        alu_opcode   = op_q;
        alu_op1      = op1_q;
        alu_op2      = op2_q;
        alu_carry_in = psw_q[PswCyBit];
        done         = 1'b1;
        if (dst_acc_q) begin
          acc_wr_en   = 1'b1;
          acc_wr_data = alu_result;
        end else begin
          ram_wr_en   = 1'b1;
          ram_wr_addr = dst_addr_q;
          ram_wr_data = alu_result;
        end
        psw_wr_en = op_writes_flags(op_q);
        if (psw_wr_en) begin
          psw_new[PswCyBit] = alu_cy;
          psw_new[PswAcBit] = alu_ac;
          psw_new[PswOvBit] = alu_ov;
        end
`ifdef ALU_SEQ_PARITY_EN
        if (dst_acc_q) begin
          psw_new[PswPBit] = ^alu_result;
          psw_wr_en        = 1'b1;
        end
`endif
        if (psw_wr_en) begin
          psw_wr_data = psw_new;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= '0;
      dst_acc_q  <= 1'b0;
      dst_addr_q <= '0;
      src_sel_q  <= '0;
      src_addr_q <= '0;
      imm_q      <= '0;
      acc_q      <= '0;
      psw_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dst_acc_q  <= dst_acc_d;
      dst_addr_q <= dst_addr_d;
      src_sel_q  <= src_sel_d;
      src_addr_q <= src_addr_d;
      imm_q      <= imm_d;
      acc_q      <= acc_d;
      psw_q      <= psw_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural 8051 ALU and a RAM with
// one-cycle read latency surround the DUT; a transaction-level model of ACC,
// PSW and RAM predicts every strobe of each operation.
module tb_alu_sequencer;

`ifdef ALU_SEQ_PARITY_EN
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_dst_acc;
  logic [2:0] req_op;
  logic [7:0] req_dst_addr, req_src_addr, req_imm;
  logic [1:0] req_src_sel;
  logic [7:0] acc_in, psw_in;
  logic       ram_rd_en, ram_wr_en, acc_wr_en, psw_wr_en, done;
  logic [7:0] ram_rd_addr, ram_rd_data, ram_wr_addr, ram_wr_data;
  logic [7:0] acc_wr_data, psw_wr_data;
  logic [2:0] alu_opcode;
  logic [7:0] alu_op1, alu_op2, alu_result;
  logic       alu_carry_in, alu_cy, alu_ac, alu_ov;

  logic [7:0] mem [256];
  logic [7:0] acc_m, psw_m;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // 8051 ALU behaviour: {result, cy, ac, ov}. Flags of non-arithmetic ops are
  // deliberately nonzero garbage so that a sequencer using them is exposed.
  function automatic logic [10:0] alu_calc(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic c);
    logic [8:0] s;
    logic [7:0] r;
    logic       cy, ac, ov, cin;
    cy = a[0];
    ac = b[1];
    ov = 1'b1;
    r  = '0;
    case (op)
      3'd0: r = a + 8'd1;
      3'd1: r = a - 8'd1;
      3'd2, 3'd3: begin
        cin = (op == 3'd3) ? c : 1'b0;
        s   = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        r   = s[7:0];
        cy  = s[8];
        ac  = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin}) > 5'd15;
        ov  = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd4: begin
        r  = a - b - {7'd0, c};
        cy = {1'b0, a} < ({1'b0, b} + {8'd0, c});
        ac = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'd0, c});
        ov = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = a & b;
    endcase
    return {r, cy, ac, ov};
  endfunction

  assign {alu_result, alu_cy, alu_ac, alu_ov} = alu_calc(alu_opcode, alu_op1, alu_op2,
                                                         alu_carry_in);

  always @(posedge clock) ram_rd_data <= ram_rd_en ? mem[ram_rd_addr] : 8'hEE;

  alu_sequencer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_dst_acc(req_dst_acc), .req_dst_addr(req_dst_addr), .req_src_sel(req_src_sel),
    .req_src_addr(req_src_addr), .req_imm(req_imm), .acc_in(acc_in), .psw_in(psw_in),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .acc_wr_en(acc_wr_en), .acc_wr_data(acc_wr_data),
    .psw_wr_en(psw_wr_en), .psw_wr_data(psw_wr_data),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_cy(alu_cy),
    .alu_ac(alu_ac), .alu_ov(alu_ov), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_ready"}, 32'(req_ready), 32'd1);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_ens"}, 32'({ram_rd_en, ram_wr_en, acc_wr_en, psw_wr_en}), 32'd0);
    check({pfx, "_addrs"}, 32'({ram_rd_addr, ram_wr_addr}), 32'd0);
    check({pfx, "_data"}, 32'({ram_wr_data, acc_wr_data, psw_wr_data}), 32'd0);
    check({pfx, "_alu"}, 32'({alu_opcode, alu_op1, alu_op2, alu_carry_in}), 32'd0);
  endtask

  // Garbage on every request-side input while the sequencer is busy.
  task automatic scramble(input logic allow_valid);
    req_valid    = allow_valid & 1'($urandom);
    req_op       = 3'($urandom);
    req_dst_acc  = 1'($urandom);
    req_dst_addr = 8'($urandom);
    req_src_sel  = 2'($urandom);
    req_src_addr = 8'($urandom);
    req_imm      = 8'($urandom);
    acc_in       = 8'($urandom);
    psw_in       = 8'($urandom);
  endtask

  // One full operation; returns at the negedge of its WB cycle.
  task automatic run_txn(input logic [2:0] op, input logic dacc, input logic [7:0] daddr,
                         input logic [1:0] sel, input logic [7:0] saddr,
                         input logic [7:0] imm);
    logic [7:0] a, b, r, epsw;
    logic       cy, ac, ov, arith, epsw_en;
    a = dacc ? acc_m : mem[daddr];
    case (sel)
      2'b00:   b = mem[saddr];
      2'b10:   b = acc_m;
      default: b = imm;
    endcase
    {r, cy, ac, ov} = alu_calc(op, a, b, psw_m[7]);
    arith = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
    epsw  = psw_m;
    if (arith) begin
      epsw[7] = cy;
      epsw[6] = ac;
      epsw[2] = ov;
    end
    if (Par && dacc) epsw[0] = ^r;
    epsw_en = arith || (Par && dacc);

    @(negedge clock);
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_done", 32'(done), 32'd0);
    req_valid = 1'b1; req_op = op; req_dst_acc = dacc; req_dst_addr = daddr;
    req_src_sel = sel; req_src_addr = saddr; req_imm = imm;
    acc_in = acc_m; psw_in = psw_m;

    @(negedge clock);  // RD1
    scramble(1'b1);
    check("rd1_ready", 32'(req_ready), 32'd0);
    check("rd1_rd_en", 32'(ram_rd_en), 32'(!dacc));
    if (!dacc) check("rd1_rd_addr", 32'(ram_rd_addr), 32'(daddr));
    check("rd1_done", 32'(done), 32'd0);

    @(negedge clock);  // RD2
    scramble(1'b1);
    check("rd2_rd_en", 32'(ram_rd_en), 32'(sel == 2'b00));
    if (sel == 2'b00) check("rd2_rd_addr", 32'(ram_rd_addr), 32'(saddr));

    @(negedge clock);  // EXEC
    scramble(1'b1);
    check("ex_opcode", 32'(alu_opcode), 32'(op));
    check("ex_op1", 32'(alu_op1), 32'(a));
    check("ex_op2", 32'(alu_op2), 32'(b));
    check("ex_cin", 32'(alu_carry_in), 32'(psw_m[7]));
    check("ex_quiet", 32'({acc_wr_en, ram_wr_en, psw_wr_en, done}), 32'd0);

    @(negedge clock);  // WB
    scramble(1'b0);
    check("wb_done", 32'(done), 32'd1);
    check("wb_ready", 32'(req_ready), 32'd0);
    check("wb_op1_hold", 32'(alu_op1), 32'(a));
    check("wb_op2_hold", 32'(alu_op2), 32'(b));
    check("wb_acc_en", 32'(acc_wr_en), 32'(dacc));
    check("wb_ram_en", 32'(ram_wr_en), 32'(!dacc));
    if (dacc) check("wb_acc_data", 32'(acc_wr_data), 32'(r));
    else begin
      check("wb_ram_addr", 32'(ram_wr_addr), 32'(daddr));
      check("wb_ram_data", 32'(ram_wr_data), 32'(r));
    end
    check("wb_psw_en", 32'(psw_wr_en), 32'(epsw_en));
    if (epsw_en) check("wb_psw_data", 32'(psw_wr_data), 32'(epsw));

    if (dacc) acc_m = r;
    else mem[daddr] = r;
    if (epsw_en) psw_m = epsw;
  endtask

  initial begin
    logic [7:0] orig;
    logic [7:0] da;
    reset = 1'b1;
    scramble(1'b0);
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    acc_m = 8'h00;
    psw_m = 8'h00;
    repeat (2) @(negedge clock);
    check_quiet("rst");
    reset = 1'b0;

    // ADD ACC=0x7F + #0x01: 0x80, CY0 AC1 OV1.
    acc_m = 8'h7F; psw_m = 8'h00;
    run_txn(3'd2, 1'b1, 8'h00, 2'b01, 8'h00, 8'h01);
    // INC RAM[0x30]=0xFF wraps to 0x00, no PSW write (ACC not touched).
    mem[8'h30] = 8'hFF;
    run_txn(3'd0, 1'b0, 8'h30, 2'b01, 8'h00, 8'h00);
    // ADDC with CY=1, ACC=0x05, src RAM[0x40]=0x10.
    psw_m = 8'h80; acc_m = 8'h05; mem[8'h40] = 8'h10;
    run_txn(3'd3, 1'b1, 8'h00, 2'b00, 8'h40, 8'h00);
    // ORL ACC=0x05 | 0x02 = 0x07 (odd parity).
    acc_m = 8'h05;
    run_txn(3'd5, 1'b1, 8'h00, 2'b01, 8'h00, 8'h02);
    // Same address for destination and source.
    run_txn(3'd4, 1'b0, 8'h55, 2'b00, 8'h55, 8'h00);
    // Reserved src_sel behaves as immediate.
    run_txn(3'd6, 1'b1, 8'h00, 2'b11, 8'h12, 8'hA5);

    // req_valid held for 10 accept edges: accepts at 0 and 5, done in 4 and 9.
    @(negedge clock);
    orig = acc_m;
    req_valid = 1'b1; req_op = 3'd6; req_dst_acc = 1'b1; req_dst_addr = 8'h00;
    req_src_sel = 2'b01; req_src_addr = 8'h00; req_imm = 8'h0F;
    acc_in = orig; psw_in = psw_m;
    for (int k = 0; k <= 10; k++) begin
      if (k == 10) req_valid = 1'b0;
      check($sformatf("held_ready_c%0d", k), 32'(req_ready), 32'(k == 0 || k == 5 || k == 10));
      check($sformatf("held_done_c%0d", k), 32'(done), 32'(k == 4 || k == 9));
      if (k == 4 || k == 9) check("held_acc_data", 32'(acc_wr_data), 32'(orig ^ 8'h0F));
      @(negedge clock);
    end
    check("held_idle_after", 32'(req_ready), 32'd1);
    acc_m = orig ^ 8'h0F;
    if (Par) psw_m[0] = ^acc_m;

    // Reset in EXEC: outputs drop at once and no writeback follows.
    req_valid = 1'b1; req_op = 3'd2; req_dst_acc = 1'b0; req_dst_addr = 8'h20;
    req_src_sel = 2'b01; req_imm = 8'h33; acc_in = acc_m; psw_in = psw_m;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("pre_rst_exec_op", 32'(alu_opcode), 32'd2);
    reset = 1'b1;
    #1;
    check_quiet("rst_exec");
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("post_rst_quiet", 32'({ram_wr_en, acc_wr_en, psw_wr_en, done, ram_rd_en}), 32'd0);
      @(negedge clock);
    end

    // Randomised operations chained through the ACC/PSW/RAM model.
    for (int n = 0; n < 150; n++) begin
      psw_m = 8'($urandom);
      da = 8'($urandom);
      run_txn(3'($urandom), 1'($urandom), da, 2'($urandom),
              ($urandom_range(0, 3) == 0) ? da : 8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
